// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I OP/OP-IMM decode into a registered ALU32I bundle behind a 2-entry elastic buffer (option macro ALU_ISSUE_UPPER_EN adds LUI/AUIPC)
module alu_issue_stage #(
  parameter int XLEN         = 32,
  parameter int ILLEGAL_PASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_selectop,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      sel;
    logic [4:0]      rd;
    logic            ill;
  } bundle_t;
  bundle_t dec, out_d, out_q, skid_d, skid_q;
  logic out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
  logic is_op, is_imm, is_lui, is_auipc, legal, push, pop;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_b, upper_b;
  logic unused_ok;
  assign op        = in_instr[6:0];
  assign f3        = in_instr[14:12];
  assign f7        = in_instr[31:25];
  assign is_op     = op == 7'b0110011;
  assign is_imm    = op == 7'b0010011;
  assign imm_b     = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, in_instr[24:20]} : {{20{in_instr[31]}}, in_instr[31:20]};
  assign upper_b   = {in_instr[31:12], 12'b0};
  assign unused_ok = &{1'b0, in_instr[19:15]};
  // Instruction decode; illegal bundles carry zero operands and opcode
  always_comb begin
`ifdef ALU_ISSUE_UPPER_EN
    is_lui   = op == 7'b0110111;
    is_auipc = op == 7'b0010111;
`else
    is_lui   = 1'b0;
    is_auipc = 1'b0;
`endif
    legal = (is_op && (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
         || (is_imm && (f3 == 3'b001 ? f7 == 7'b0000000 :
                        f3 == 3'b101 ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1))
         || is_lui || is_auipc;
    dec.a   = !legal ? '0 : is_auipc ? in_pc : is_lui ? '0 : in_rs1;
    dec.b   = !legal ? '0 : is_op ? in_rs2 : is_imm ? imm_b : upper_b;
    dec.sel = !legal ? 4'b0 : is_op ? {in_instr[30], f3} :
              is_imm ? {f3 == 3'b101 && in_instr[30], f3} : 4'b0;
    dec.rd  = in_instr[11:7];
    dec.ill = !legal;
  end
  assign push      = in_valid && !skid_valid_q && (legal || ILLEGAL_PASS != 0);
  assign pop       = out_valid_q && out_ready;
  assign in_ready  = !skid_valid_q;
  // Elastic buffer next state: output slot refills from skid first, then input
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (pop || !out_valid_q) begin
      out_valid_d  = skid_valid_q || push;
      out_d        = skid_valid_q ? skid_q : push ? dec : out_q;
      skid_valid_d = 1'b0;
    end else if (push) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end
  // State registers; reset discards both entries
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
  assign out_valid    = out_valid_q;
  assign out_a        = out_q.a;
  assign out_b        = out_q.b;
  assign out_selectop = out_q.sel;
  assign out_rd       = out_q.rd;
  assign out_illegal  = out_q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed-vector self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_rs1 = '0, in_rs2 = '0, in_pc = '0;
  logic in_ready, out_valid, out_illegal;
  logic [31:0] out_a, out_b;
  logic [3:0] out_selectop;
  logic [4:0] out_rd;
  logic d_in_ready, d_out_valid, d_out_illegal;
  logic [31:0] d_out_a, d_out_b;
  logic [3:0] d_out_selectop;
  logic [4:0] d_out_rd;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_selectop(out_selectop), .out_rd(out_rd), .out_illegal(out_illegal)
  );
  alu_issue_stage #(.ILLEGAL_PASS(0)) dut_drop (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_a(d_out_a), .out_b(d_out_b), .out_selectop(d_out_selectop), .out_rd(d_out_rd), .out_illegal(d_out_illegal)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    in_instr = instr;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] sel, input logic [4:0] rd, input logic ill);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".a"}, out_a, a);
    check({tag, ".b"}, out_b, b);
    check({tag, ".sel"}, {28'b0, out_selectop}, {28'b0, sel});
    check({tag, ".rd"}, {27'b0, out_rd}, {27'b0, rd});
    check({tag, ".ill"}, {31'b0, out_illegal}, {31'b0, ill});
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst.valid", {31'b0, out_valid}, 32'd0);
    check("rst.ready", {31'b0, in_ready}, 32'd1);
    check("rst.a", out_a, 32'd0);
    check("rst.b", out_b, 32'd0);
    check("rst.sel", {28'b0, out_selectop}, 32'd0);
    check("rst.rd", {27'b0, out_rd}, 32'd0);
    check("rst.ill", {31'b0, out_illegal}, 32'd0);
    issue(32'hFC308293, 32'h0, 32'h0);
    expect_out("addi", 32'h0, 32'hFFFFFFC3, 4'b0000, 5'd5, 1'b0);
    issue(32'h402081B3, 32'hFFFFFFC3, 32'h5);
    expect_out("sub", 32'hFFFFFFC3, 32'h5, 4'b1000, 5'd3, 1'b0);
    issue(32'h4050D213, 32'h80000000, 32'h0);
    expect_out("srai", 32'h80000000, 32'h5, 4'b1101, 5'd4, 1'b0);
    issue(32'h40509213, 32'h80000000, 32'h0);
    expect_out("slli_bad", 32'h0, 32'h0, 4'b0000, 5'd4, 1'b1);
    issue(32'h0020E333, 32'h0F0F0F0F, 32'h12345678);
    expect_out("or", 32'h0F0F0F0F, 32'h12345678, 4'b0110, 5'd6, 1'b0);
    issue(32'h4020E333, 32'h0F0F0F0F, 32'h12345678);
    expect_out("or_f7_bad", 32'h0, 32'h0, 4'b0000, 5'd6, 1'b1);
    issue(32'h022081B3, 32'h11, 32'h22);
    expect_out("mul_pass", 32'h0, 32'h0, 4'b0000, 5'd3, 1'b1);
    step();
    check("drain.valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    issue(32'h00100093, 32'h0, 32'h0);
    check("bp1.ready", {31'b0, in_ready}, 32'd1);
    issue(32'h00200113, 32'h0, 32'h0);
    check("bp2.ready", {31'b0, in_ready}, 32'd0);
    in_instr = 32'h00300193;
    in_valid = 1'b1;
    step();
    check("bp3.ready", {31'b0, in_ready}, 32'd0);
    expect_out("hold_a", 32'h0, 32'h1, 4'b0000, 5'd1, 1'b0);
    out_ready = 1'b1;
    step();
    expect_out("fifo_b", 32'h0, 32'h2, 4'b0000, 5'd2, 1'b0);
    check("fifo_b.ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    expect_out("fifo_c", 32'h0, 32'h3, 4'b0000, 5'd3, 1'b0);
    step();
    check("fifo_end.valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    issue(32'h00100093, 32'h0, 32'h0);
    issue(32'h00200113, 32'h0, 32'h0);
    check("pre_rst.ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst.valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst.ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    check("mid_rst.quiet", {31'b0, out_valid}, 32'd0);
    issue(32'h022081B3, 32'h11, 32'h22);
    expect_out("mul_pass2", 32'h0, 32'h0, 4'b0000, 5'd3, 1'b1);
    check("mul_drop.valid", {31'b0, d_out_valid}, 32'd0);
    check("mul_drop.ready", {31'b0, d_in_ready}, 32'd1);
    issue(32'h00500293, 32'h7, 32'h0);
    check("drop_next.valid", {31'b0, d_out_valid}, 32'd1);
    check("drop_next.b", d_out_b, 32'h5);
    in_pc = 32'h100;
`ifdef ALU_ISSUE_UPPER_EN
    issue(32'h12345297, 32'h7, 32'h0);
    expect_out("auipc", 32'h100, 32'h12345000, 4'b0000, 5'd5, 1'b0);
    issue(32'h123452B7, 32'h7, 32'h0);
    expect_out("lui", 32'h0, 32'h12345000, 4'b0000, 5'd5, 1'b0);
`else
    issue(32'h12345297, 32'h7, 32'h0);
    expect_out("auipc_bad", 32'h0, 32'h0, 4'b0000, 5'd5, 1'b1);
    issue(32'h123452B7, 32'h7, 32'h0);
    expect_out("lui_bad", 32'h0, 32'h0, 4'b0000, 5'd5, 1'b1);
`endif
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
